// File: rtl/risc_pkg.sv
// Shared definitions for the RISC fetch stage: branch-select encodings,
// datapath width and the NOP instruction word.
package risc_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BS_SEQ  = 2'b00,
    BS_COND = 2'b01,
    BS_JMP  = 2'b10,
    BS_JMPR = 2'b11
  } bs_e;

  localparam logic [XLEN-1:0] NOP_IR = 32'h0000_0000;

endpackage

// File: rtl/risc_fetch_ring.sv
// Fetch ring: DEPTH slots of {pc, ir, filled}. Slots are allocated when a
// request is accepted, filled in order as responses return and popped in
// order by the IF/DOF register. A clear drops every slot at once.
module risc_fetch_ring
  import risc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_ir,
  input  logic            pop_en,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_ir,
  output logic [PW:0]     used,
  output logic [PW:0]     unfilled
);

  logic [PW-1:0]   alloc_q, alloc_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW:0]     used_q, used_d;
  logic [PW:0]     unfilled_q, unfilled_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [XLEN-1:0] ir_q [DEPTH];
  logic [XLEN-1:0] ir_d [DEPTH];

  // Next-state for pointers, occupancy counts, filled flags and slot payload
  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    used_d     = used_q;
    unfilled_d = unfilled_q;
    filled_d   = filled_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    if (clear) begin
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      used_d     = '0;
      unfilled_d = '0;
      filled_d   = '0;
    end else begin
      if (alloc_en) begin
        pc_d[alloc_q]     = alloc_pc;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + 1'b1;
      end
      if (fill_en) begin
        ir_d[fill_q]     = fill_ir;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + 1'b1;
      end
      // Clearing the flag on pop keeps a stale slot from looking deliverable
      // once the head wraps back onto it with the ring empty.
      if (pop_en) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      used_d     = used_q + {{PW{1'b0}}, alloc_en} - {{PW{1'b0}}, pop_en};
      unfilled_d = unfilled_q + {{PW{1'b0}}, alloc_en} - {{PW{1'b0}}, fill_en};
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      used_q     <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      used_q     <= used_d;
      unfilled_q <= unfilled_d;
      filled_q   <= filled_d;
    end
  end

  // Slot payload storage; only meaningful while the matching flag says so
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    ir_q <= ir_d;
  end

  assign head_filled = filled_q[head_q];
  assign head_pc     = pc_q[head_q];
  assign head_ir     = ir_q[head_q];
  assign used        = used_q;
  assign unfilled    = unfilled_q;

endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests,
// buffers returned instructions in the fetch ring and presents them on the
// IF/DOF register. Taken branches/jumps from EX flush the ring and count the
// still-outstanding responses so they can be dropped when they arrive.
module risc_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = risc_pkg::NOP_IR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_WB_Z,
  input  logic        EX_WB_PS,
  input  logic [1:0]  EX_WB_BS,
  input  logic [31:0] EX_WB_BrA,
  input  logic [31:0] EX_WB_RAA,
  input  logic        dof_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] IF_DOF_PC,
  output logic [31:0] IF_DOF_IR,
  output logic [31:0] IF_DOF_NPC,
  output logic        IF_DOF_valid,
  output logic        if_redirect
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = DEPTH[PW+1:0];

  logic        take;
  logic [31:0] target;
  logic        req_valid;
  logic        handshake;
  logic        rsp_discard;
  logic        fill_en;
  logic        pop_en;

  logic        head_filled;
  logic [31:0] head_pc;
  logic [31:0] head_ir;
  logic [PW:0] used;
  logic [PW:0] unfilled;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [PW:0] discard_q, discard_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_ir_q, if_ir_d;
  logic [31:0] if_npc_q, if_npc_d;
  logic        if_valid_q, if_valid_d;
  logic        redirect_q, redirect_d;

  // Redirect decode from the EX/WB branch fields
  always_comb begin
    take   = 1'b0;
    target = EX_WB_BrA;
    case (EX_WB_BS)
      risc_pkg::BS_COND: take = EX_WB_Z ^ EX_WB_PS;
      risc_pkg::BS_JMP:  take = 1'b1;
      risc_pkg::BS_JMPR: begin
        take   = 1'b1;
        target = EX_WB_RAA;
      end
      default: take = 1'b0;
    endcase
  end

  // Request/response gating: discarded responses still occupy ring capacity
  always_comb begin
    req_valid   = !reset && !take &&
                  (({1'b0, used} + {1'b0, discard_q}) < DEPTH_W);
    handshake   = req_valid && imem_req_ready;
    rsp_discard = imem_rsp_valid && (discard_q != '0);
    fill_en     = imem_rsp_valid && !rsp_discard && (unfilled != '0);
    pop_en      = !take && !dof_stall && head_filled;
  end

  risc_fetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .clear       (take),
    .alloc_en    (handshake),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (fill_en),
    .fill_ir     (imem_rsp_data),
    .pop_en      (pop_en),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_ir     (head_ir),
    .used        (used),
    .unfilled    (unfilled)
  );

  // Next fetch PC, discard count and IF/DOF register contents
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if_pc_d    = if_pc_q;
    if_ir_d    = if_ir_q;
    if_npc_d   = if_npc_q;
    if_valid_d = if_valid_q;
    redirect_d = take;
    if (take) begin
      // Every unfilled slot still has a response coming; one arriving right
      // now is dropped here and so is not counted.
      fetch_pc_d = target;
      discard_d  = discard_q + unfilled - {{PW{1'b0}}, imem_rsp_valid};
      if_valid_d = 1'b0;
      if_ir_d    = NOP_IR;
    end else begin
      if (handshake) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
      end
      if (rsp_discard) begin
        discard_d = discard_q - {{PW{1'b0}}, 1'b1};
      end
      if (!dof_stall) begin
        if (head_filled) begin
          if_pc_d    = head_pc;
          if_ir_d    = head_ir;
          if_npc_d   = head_pc + 32'd1;
          if_valid_d = 1'b1;
        end else begin
          if_valid_d = 1'b0;
          if_ir_d    = NOP_IR;
        end
      end
    end
  end

  // State register; the IF/DOF word has defined contents out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      if_pc_q    <= RESET_PC;
      if_ir_q    <= NOP_IR;
      if_npc_q   <= RESET_PC + 32'd1;
      if_valid_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      if_pc_q    <= if_pc_d;
      if_ir_q    <= if_ir_d;
      if_npc_q   <= if_npc_d;
      if_valid_q <= if_valid_d;
      redirect_q <= redirect_d;
    end
  end

  // Flag a response for which no request is outstanding
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && (discard_q == '0) && (unfilled == '0)))
        else $error("risc_fetch_unit: imem response with no outstanding request");
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = fetch_pc_q;
  assign IF_DOF_PC      = if_pc_q;
  assign IF_DOF_IR      = if_ir_q;
  assign IF_DOF_NPC     = if_npc_q;
  assign IF_DOF_valid   = if_valid_q;
  assign if_redirect    = redirect_q;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Directed bench for risc_fetch_unit with a behavioural memory and a
// scoreboard of accepted fetches that are expected on IF/DOF in order.
module tb_risc_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_z, ex_ps;
  logic [1:0]  ex_bs;
  logic [31:0] ex_bra, ex_raa;
  logic        dof_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_pc, if_ir, if_npc;
  logic        if_valid, if_redirect;

  risc_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP_IR   (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .EX_WB_Z        (ex_z),
    .EX_WB_PS       (ex_ps),
    .EX_WB_BS       (ex_bs),
    .EX_WB_BrA      (ex_bra),
    .EX_WB_RAA      (ex_raa),
    .dof_stall      (dof_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IF_DOF_PC      (if_pc),
    .IF_DOF_IR      (if_ir),
    .IF_DOF_NPC     (if_npc),
    .IF_DOF_valid   (if_valid),
    .if_redirect    (if_redirect)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int gen; } pend_t;
  typedef struct { logic [31:0] pc; bit filled; int fcyc; } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int cur_gen = 0;
  bit cur_rsp_dead = 1'b0;
  bit m_known = 1'b0;

  logic [31:0] m_fpc, m_pc, m_ir, m_npc;
  logic        m_valid, m_redir;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: check this cycle's outputs, advance the model, drive memory
  task automatic tick();
    bit    take_now;
    bit    exp_req;
    int    dead_cnt;
    pend_t p;
    exp_t  e;
    @(negedge clk);
    take_now = !reset && ((ex_bs == 2'b01 && (ex_z ^ ex_ps)) || ex_bs[1]);
    if (m_known) begin
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      chk("if_pc", if_pc, m_pc);
      chk("if_ir", if_ir, m_ir);
      chk("if_npc", if_npc, m_npc);
      chk("if_redirect", {31'd0, if_redirect}, {31'd0, m_redir});
      chk("imem_addr", imem_addr, m_fpc);
    end
    dead_cnt = cur_rsp_dead ? 1 : 0;
    foreach (pend_q[i]) if (pend_q[i].gen != cur_gen) dead_cnt++;
    exp_req = !reset && !take_now && ((exp_q.size() + dead_cnt) < DEPTH);
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
    if (exp_req && imem_req_ready) begin
      pend_q.push_back('{addr: m_fpc, due: cyc + lat, gen: cur_gen});
      exp_q.push_back('{pc: m_fpc, filled: 1'b0, fcyc: 0});
      m_fpc = m_fpc + 32'd1;
    end
    if (reset) begin
      m_fpc = RESET_PC; m_pc = RESET_PC; m_npc = RESET_PC + 32'd1;
      m_ir = NOP; m_valid = 1'b0; m_redir = 1'b0;
      exp_q.delete(); pend_q.delete(); cur_gen++;
      m_known = 1'b1;
    end else if (take_now) begin
      m_fpc = (ex_bs == 2'b11) ? ex_raa : ex_bra;
      exp_q.delete(); cur_gen++;
      m_valid = 1'b0; m_ir = NOP; m_redir = 1'b1;
    end else begin
      m_redir = 1'b0;
      if (!dof_stall) begin
        if (exp_q.size() > 0 && exp_q[0].filled && exp_q[0].fcyc < cyc) begin
          e = exp_q.pop_front();
          m_valid = 1'b1; m_pc = e.pc; m_ir = memf(e.pc); m_npc = e.pc + 32'd1;
        end else begin
          m_valid = 1'b0; m_ir = NOP;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    cur_rsp_dead   = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(p.addr);
      if (p.gen != cur_gen) begin
        cur_rsp_dead = 1'b1;
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].filled) begin
            e = exp_q[i]; e.filled = 1'b1; e.fcyc = cyc; exp_q[i] = e;
            break;
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; ex_z = 1'b0; ex_ps = 1'b0; ex_bs = 2'b00;
    ex_bra = 32'h0; ex_raa = 32'h0; dof_stall = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    m_fpc = RESET_PC; m_pc = RESET_PC; m_npc = RESET_PC + 32'd1;
    m_ir = NOP; m_valid = 1'b0; m_redir = 1'b0;

    // T1: reset, then sequential fetch with single-cycle memory
    run(3);
    reset = 1'b0;
    run(10);

    // T2: hold DOF long enough for the ring to fill, then release
    dof_stall = 1'b1;
    run(4);
    dof_stall = 1'b0;
    run(8);

    // T3: taken conditional branch, then the same branch not taken
    ex_bs = 2'b01; ex_ps = 1'b0; ex_z = 1'b1; ex_bra = 32'h0000_0040;
    run(1);
    ex_bs = 2'b00;
    run(6);
    ex_bs = 2'b01; ex_ps = 1'b0; ex_z = 1'b0;
    run(1);
    ex_bs = 2'b00;
    run(4);

    // T4: three-cycle memory, register jump while fetches are in flight
    lat = 3;
    run(6);
    ex_bs = 2'b11; ex_raa = 32'h0000_0100;
    run(1);
    ex_bs = 2'b00;
    run(12);

    // T5: memory not ready, then a jump while still not ready
    imem_req_ready = 1'b0;
    run(5);
    ex_bs = 2'b10; ex_bra = 32'h0000_0200;
    run(1);
    ex_bs = 2'b00;
    run(2);
    imem_req_ready = 1'b1;
    run(8);

    // T6: reset with fetches outstanding, then restart
    lat = 2;
    run(3);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(10);

    // Drain: stop new requests and let every accepted fetch come out
    imem_req_ready = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
